// File: rtl/mdu.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// mult/multu use radix-2 shift-add; div/divu use restoring division.
// Both share one 64-bit working register and take ITER cycles.
module mdu #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [63:0] acc;       // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] opnd;      // multiplicand or divisor magnitude
  logic        is_div;
  logic        neg_res;   // negate product / quotient
  logic        neg_rem;   // negate remainder (dividend sign)
  logic        div_zero;

  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] add_sum;
  logic [32:0] shifted;
  logic [63:0] acc_nxt;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Operand magnitudes at accept, one iteration step, and sign fix-up of the final step
  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = is_signed & a[31];
    b_neg     = is_signed & b[31];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;

    add_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    shifted = acc[63:31];
    acc_nxt = {add_sum, acc[31:1]};
    if (is_div) begin
      if (shifted >= {1'b0, opnd}) begin
        acc_nxt = {32'(shifted - {1'b0, opnd}), acc[30:0], 1'b1};
      end else begin
        acc_nxt = {shifted[31:0], acc[30:0], 1'b0};
      end
    end

    prod_fix = neg_res ? -acc_nxt : acc_nxt;
    quo_fix  = neg_res ? -acc_nxt[31:0] : acc_nxt[31:0];
    rem_fix  = neg_rem ? -acc_nxt[63:32] : acc_nxt[63:32];
  end

  // Control FSM, iteration datapath and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      acc      <= 64'd0;
      opnd     <= 32'd0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state    <= RUN;
                busy     <= 1'b1;
                cnt      <= 6'(ITER);
                is_div   <= (op == OP_DIV) || (op == OP_DIVU);
                neg_res  <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                div_zero <= (b == 32'd0);
                if ((op == OP_DIV) || (op == OP_DIVU)) begin
                  acc  <= {32'd0, a_mag};
                  opnd <= b_mag;
                end else begin
                  acc  <= {32'd0, b_mag};
                  opnd <= a_mag;
                end
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - 6'd1;
          acc <= acc_nxt;
          if (cnt == 6'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (!is_div) begin
              hi <= prod_fix[63:32];
              lo <= prod_fix[31:0];
            end else if (!div_zero) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
